// File: rtl/wb_cmd_master.sv
// Wishbone classic single-beat initiator fed by a valid/ready command stream, with bounded retry.
// Define WB_CMD_MASTER_TIMEOUT_EN to build the per-cycle stb timeout (status 11).
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr,
  input  logic [DATA_WIDTH-1:0]   cmd_dat,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic [1:0]              rsp_status,
  output logic                    busy,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2, RESP = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic                    cyc_q, cyc_d;
  logic                    busy_q, busy_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SELECT_WIDTH-1:0] sel_q, sel_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic                    tmo_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // The final stb cycle is the one where the counter already reads TIMEOUT_CYCLES-1.
  assign tmo_hit = (tmo_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= IDLE;
      retry_q      <= '0;
      cyc_q        <= 1'b0;
      busy_q       <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= 2'b00;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      cyc_q        <= cyc_d;
      busy_q       <= busy_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Next state; terminations resolve err > ack > rty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_valid) state_d = BUS; else state_d = IDLE;
      BUS: begin
        if (wb_err_i || wb_ack_i)  state_d = RESP;
        else if (wb_rty_i)         state_d = (retry_q == RETRY_MAX) ? RESP : GAP;
        else if (tmo_hit)          state_d = RESP;
        else                       state_d = BUS;
      end
      GAP:  state_d = BUS;
      RESP: if (rsp_ready) state_d = IDLE; else state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Registered output and counter updates.
  always_comb begin
    cyc_d        = (state_d == BUS);
    busy_d       = (state_d != IDLE);
    rsp_valid_d  = (state_d == RESP);
    retry_d      = retry_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          sel_d   = cmd_sel;
          retry_d = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          retry_d = retry_q;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          rsp_status_d = ST_ERR;
          rsp_dat_d    = '0;
        end else if (wb_ack_i) begin
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
        end else if (wb_rty_i) begin
          if (retry_q == RETRY_MAX) begin
            rsp_status_d = ST_RTY;
            rsp_dat_d    = '0;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end else if (tmo_hit) begin
          rsp_status_d = ST_TMO;
          rsp_dat_d    = '0;
        end else begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end
      GAP: begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        tmo_d = '0;
`endif
      end
      RESP:    rsp_status_d = rsp_status_q;
      default: rsp_status_d = rsp_status_q;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = busy_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;

endmodule
